// File: rtl/t5_dmem.sv
// t5 data-memory stage: one load/store per transaction on a single-outstanding
// stb/ack bus, with load alignment/extension, misalignment flag and stall.
// Optional bus watchdog: define T5_DMEM_TIMEOUT_EN.
`default_nettype none

module t5_dmem #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned TMO  = 255
) (
    input  logic            sclk,
    input  logic            srst,
    input  logic            sena,
    input  logic [4:0]      xopc,
    input  logic [2:0]      xfn3,
    input  logic [XLEN-1:0] xadr,
    input  logic [XLEN-1:0] xdat,
    output logic [XLEN-1:0] dwb_adr,
    output logic [XLEN-1:0] dwb_dto,
    output logic [3:0]      dwb_sel,
    output logic            dwb_wre,
    output logic            dwb_stb,
    input  logic            dwb_ack,
    input  logic [XLEN-1:0] dwb_dti,
    output logic [XLEN-1:0] mlod,
    output logic [4:0]      mopc,
    output logic            mmis,
    output logic            mberr,
    output logic            mstl
);

    localparam logic [4:0] OPC_LOAD  = 5'b00000;
    localparam logic [4:0] OPC_STORE = 5'b01000;
    localparam logic [4:0] OPC_NOP   = 5'h0D;
    localparam int unsigned CW       = 8;

    // Only the 32-bit datapath and an 8-bit-representable watchdog are supported.
    if (XLEN != 32 || TMO < 1 || TMO > 255) begin : g_cfg_unsupported
        $error("t5_dmem: unsupported XLEN/TMO configuration");
    end

    typedef enum logic [0:0] {IDLE, BUSY} state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   adr_d, dto_d, mlod_d;
    logic [3:0]        sel_d;
    logic              wre_d, stb_d, mmis_d, mberr_d;
    logic [4:0]        mopc_d;
    logic [2:0]        fn3_q, fn3_d;
    logic [1:0]        lane_q, lane_d;

    logic              is_mem_c;
    logic              acc_ok_c;
    logic [3:0]        sel_c;
    logic [XLEN-1:0]   ld_c;
    logic [7:0]        byte_c;
    logic [15:0]       half_c;
    logic              tmo_hit_c;

`ifdef T5_DMEM_TIMEOUT_EN
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              mberr_q;

    assign tmo_hit_c = (state_q == BUSY) && (cnt_q == CW'(TMO - 1));
    assign mberr     = mberr_q;
`else
    assign tmo_hit_c = 1'b0;
    assign mberr     = 1'b0;
`endif

    // Stall while a transaction is open; release in the completing cycle.
    assign mstl = (state_q == BUSY) & ~dwb_ack & ~tmo_hit_c;

    // Decode the incoming execute request: access legality and lane enables.
    always_comb begin
        is_mem_c = (xopc == OPC_LOAD) || (xopc == OPC_STORE);
        acc_ok_c = 1'b0;
        sel_c    = 4'b0000;
        unique case (xfn3)
            3'd0, 3'd4: begin
                acc_ok_c = 1'b1;
                sel_c    = 4'(4'b0001 << xadr[1:0]);
            end
            3'd1, 3'd5: begin
                acc_ok_c = ~xadr[0];
                sel_c    = 4'(4'b0011 << {xadr[1], 1'b0});
            end
            3'd2: begin
                acc_ok_c = (xadr[1:0] == 2'b00);
                sel_c    = 4'b1111;
            end
            default: begin
                acc_ok_c = 1'b0;
                sel_c    = 4'b0000;
            end
        endcase
    end

    // Lane-select and extend the returned read data for the latched access.
    always_comb begin
        byte_c = dwb_dti[{lane_q, 3'b000} +: 8];
        half_c = lane_q[1] ? dwb_dti[31:16] : dwb_dti[15:0];
        unique case (fn3_q[1:0])
            2'd0:    ld_c = {{24{~fn3_q[2] & byte_c[7]}}, byte_c};
            2'd1:    ld_c = {{16{~fn3_q[2] & half_c[15]}}, half_c};
            default: ld_c = dwb_dti;
        endcase
    end

    // Next-state and next-output logic; holds everything by default.
    always_comb begin
        state_d = state_q;
        adr_d   = dwb_adr;
        dto_d   = dwb_dto;
        sel_d   = dwb_sel;
        wre_d   = dwb_wre;
        stb_d   = dwb_stb;
        mlod_d  = mlod;
        mopc_d  = mopc;
        fn3_d   = fn3_q;
        lane_d  = lane_q;
        mmis_d  = 1'b0;
        mberr_d = 1'b0;
`ifdef T5_DMEM_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (sena) begin
                    mopc_d = xopc;
                    if (is_mem_c) begin
                        if (acc_ok_c) begin
                            adr_d   = {xadr[XLEN-1:2], 2'b00};
                            dto_d   = xdat;
                            sel_d   = sel_c;
                            fn3_d   = xfn3;
                            lane_d  = xadr[1:0];
                            stb_d   = 1'b1;
                            wre_d   = (xopc == OPC_STORE);
                            state_d = BUSY;
`ifdef T5_DMEM_TIMEOUT_EN
                            cnt_d   = '0;
`endif
                        end else begin
                            mmis_d = 1'b1;
                        end
                    end
                end
            end
            BUSY: begin
                if (dwb_ack) begin
                    stb_d   = 1'b0;
                    wre_d   = 1'b0;
                    state_d = IDLE;
                    if (!dwb_wre) begin
                        mlod_d = ld_c;
                    end
`ifdef T5_DMEM_TIMEOUT_EN
                end else if (tmo_hit_c) begin
                    stb_d   = 1'b0;
                    wre_d   = 1'b0;
                    state_d = IDLE;
                    mberr_d = 1'b1;
                    if (!dwb_wre) begin
                        mlod_d = '1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge sclk) begin
        if (srst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered bus and writeback outputs.
    always_ff @(posedge sclk) begin
        if (srst) begin
            dwb_adr <= '0;
            dwb_dto <= '0;
            dwb_sel <= 4'b0000;
            dwb_wre <= 1'b0;
            dwb_stb <= 1'b0;
            mlod    <= '0;
            mopc    <= OPC_NOP;
            mmis    <= 1'b0;
            fn3_q   <= 3'd0;
            lane_q  <= 2'd0;
        end else begin
            dwb_adr <= adr_d;
            dwb_dto <= dto_d;
            dwb_sel <= sel_d;
            dwb_wre <= wre_d;
            dwb_stb <= stb_d;
            mlod    <= mlod_d;
            mopc    <= mopc_d;
            mmis    <= mmis_d;
            fn3_q   <= fn3_d;
            lane_q  <= lane_d;
        end
    end

`ifdef T5_DMEM_TIMEOUT_EN
    // Watchdog counter and bus-error pulse.
    always_ff @(posedge sclk) begin
        if (srst) begin
            cnt_q   <= '0;
            mberr_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            mberr_q <= mberr_d;
        end
    end
`else
    // Keep the unused next-value tie-off visible to lint as consumed.
    logic unused_c;
    assign unused_c = mberr_d;
`endif

endmodule

`default_nettype wire

// File: tb/tb_t5_dmem.sv
// Self-checking bench for t5_dmem: directed cases plus randomized transactions
// checked against an arithmetic model of the load/store rules.
`timescale 1ns/1ps

module tb_t5_dmem;

    localparam logic [4:0] OPC_LOAD  = 5'b00000;
    localparam logic [4:0] OPC_STORE = 5'b01000;
    localparam logic [4:0] OPC_OP    = 5'b01100;
    localparam logic [4:0] OPC_NOP   = 5'h0D;

    logic        sclk = 1'b0;
    logic        srst, sena;
    logic [4:0]  xopc;
    logic [2:0]  xfn3;
    logic [31:0] xadr, xdat;
    logic [31:0] dwb_adr, dwb_dto, dwb_dti, mlod;
    logic [3:0]  dwb_sel;
    logic        dwb_wre, dwb_stb, dwb_ack;
    logic [4:0]  mopc;
    logic        mmis, mberr, mstl;

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] exp_mlod;
    logic [4:0]  exp_mopc;

    t5_dmem #(.XLEN(32), .TMO(4)) dut (
        .sclk(sclk), .srst(srst), .sena(sena),
        .xopc(xopc), .xfn3(xfn3), .xadr(xadr), .xdat(xdat),
        .dwb_adr(dwb_adr), .dwb_dto(dwb_dto), .dwb_sel(dwb_sel),
        .dwb_wre(dwb_wre), .dwb_stb(dwb_stb), .dwb_ack(dwb_ack),
        .dwb_dti(dwb_dti), .mlod(mlod), .mopc(mopc),
        .mmis(mmis), .mberr(mberr), .mstl(mstl)
    );

    always #5 sclk = ~sclk;

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference rules: access size is 1 << fn3[1:0] bytes at the byte offset.
    function automatic bit m_ok(input logic [2:0] f, input logic [31:0] a);
        case (f)
            3'd0, 3'd4: return 1'b1;
            3'd1, 3'd5: return (a % 2) == 0;
            3'd2:       return (a % 4) == 0;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] m_sel(input logic [2:0] f, input logic [31:0] a);
        int nbytes;
        int sh;
        nbytes = 1 << f[1:0];
        sh     = int'(a % 4);
        return 4'(((1 << nbytes) - 1) << sh);
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] d);
        longint unsigned v;
        longint unsigned mask;
        int nbits;
        nbits = 8 << f[1:0];
        v     = {32'h0, d} >> (8 * int'(a % 4));
        mask  = (64'd1 << nbits) - 64'd1;
        v     = v & mask;
        if (!f[2] && nbits < 32 && v[nbits-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    // Issue one request from IDLE and act as the bus slave with 'waits' wait cycles.
    task automatic issue(input logic [4:0] opc, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] rdat, input int waits,
                         input string tag);
        bit is_mem;
        is_mem = (opc == OPC_LOAD) || (opc == OPC_STORE);
        sena = 1'b1; xopc = opc; xfn3 = f; xadr = a; xdat = d;
        tick();
        sena = 1'b0; xopc = OPC_OP; xadr = $urandom; xdat = $urandom;
        exp_mopc = opc;
        chk({tag, ".mopc"}, 32'(mopc), 32'(exp_mopc));
        if (is_mem && m_ok(f, a)) begin
            chk({tag, ".stb"}, 32'(dwb_stb), 32'd1);
            chk({tag, ".wre"}, 32'(dwb_wre), 32'(opc == OPC_STORE));
            chk({tag, ".adr"}, dwb_adr, a & 32'hFFFF_FFFC);
            chk({tag, ".sel"}, 32'(dwb_sel), 32'(m_sel(f, a)));
            if (opc == OPC_STORE) chk({tag, ".dto"}, dwb_dto, d);
            chk({tag, ".mstl"}, 32'(mstl), 32'd1);
            for (int w = 0; w < waits; w++) begin
                tick();
                chk({tag, ".hold_stb"}, 32'(dwb_stb), 32'd1);
                chk({tag, ".hold_adr"}, dwb_adr, a & 32'hFFFF_FFFC);
                if (opc == OPC_STORE) chk({tag, ".hold_dto"}, dwb_dto, d);
                chk({tag, ".hold_mstl"}, 32'(mstl), 32'd1);
            end
            dwb_dti = rdat; dwb_ack = 1'b1;
            #1;
            chk({tag, ".ack_mstl"}, 32'(mstl), 32'd0);
            tick();
            dwb_ack = 1'b0; dwb_dti = $urandom;
            if (opc == OPC_LOAD) exp_mlod = m_load(f, a, rdat);
            chk({tag, ".done_stb"}, 32'(dwb_stb), 32'd0);
            chk({tag, ".done_wre"}, 32'(dwb_wre), 32'd0);
        end else if (is_mem) begin
            chk({tag, ".mis"}, 32'(mmis), 32'd1);
            chk({tag, ".mis_stb"}, 32'(dwb_stb), 32'd0);
            chk({tag, ".mis_mstl"}, 32'(mstl), 32'd0);
            tick();
            chk({tag, ".mis_clr"}, 32'(mmis), 32'd0);
        end else begin
            chk({tag, ".nop_stb"}, 32'(dwb_stb), 32'd0);
            chk({tag, ".nop_mis"}, 32'(mmis), 32'd0);
        end
        chk({tag, ".mlod"}, mlod, exp_mlod);
        chk({tag, ".mberr"}, 32'(mberr), 32'd0);
    endtask

    initial begin
        srst = 1'b1; sena = 1'b0; xopc = OPC_NOP; xfn3 = 3'd0; xadr = '0; xdat = '0;
        dwb_ack = 1'b0; dwb_dti = '0;
        tick(); tick();
        // Reset state
        chk("rst.stb",  32'(dwb_stb), 32'd0);
        chk("rst.wre",  32'(dwb_wre), 32'd0);
        chk("rst.sel",  32'(dwb_sel), 32'd0);
        chk("rst.adr",  dwb_adr, 32'd0);
        chk("rst.dto",  dwb_dto, 32'd0);
        chk("rst.mlod", mlod, 32'd0);
        chk("rst.mopc", 32'(mopc), 32'(OPC_NOP));
        chk("rst.mmis", 32'(mmis), 32'd0);
        chk("rst.mberr", 32'(mberr), 32'd0);
        chk("rst.mstl", 32'(mstl), 32'd0);
        srst = 1'b0;
        exp_mlod = 32'd0; exp_mopc = OPC_NOP;
        tick();

        // Directed cases
        issue(OPC_LOAD, 3'd0, 32'h0000_1003, 32'h0, 32'h80AA_BBCC, 2, "lb");
        chk("lb.value", mlod, 32'hFFFF_FF80);
        issue(OPC_LOAD, 3'd5, 32'h0000_2002, 32'h0, 32'h9ABC_1234, 0, "lhu");
        chk("lhu.value", mlod, 32'h0000_9ABC);
        issue(OPC_LOAD, 3'd1, 32'h0000_2002, 32'h0, 32'h9ABC_1234, 0, "lh");
        chk("lh.value", mlod, 32'hFFFF_9ABC);
        issue(OPC_STORE, 3'd2, 32'h0000_3000, 32'hDEAD_BEEF, 32'h1111_2222, 3, "sw");
        chk("sw.mlod_kept", mlod, 32'hFFFF_9ABC);
        issue(OPC_LOAD, 3'd2, 32'h0000_4002, 32'h0, 32'h0, 0, "lw_mis");
        issue(OPC_STORE, 3'd3, 32'h0000_4000, 32'h0, 32'h0, 0, "fn3_bad");
        issue(OPC_LOAD, 3'd4, 32'h0000_5001, 32'h0, 32'h1234_F600, 1, "lbu");
        chk("lbu.value", mlod, 32'h0000_00F6);

        // Stray ack while idle is ignored
        dwb_ack = 1'b1; dwb_dti = 32'h5555_5555;
        tick();
        dwb_ack = 1'b0;
        chk("stray.stb", 32'(dwb_stb), 32'd0);
        chk("stray.mlod", mlod, exp_mlod);

        // Reset while busy, late ack ignored
        sena = 1'b1; xopc = OPC_LOAD; xfn3 = 3'd2; xadr = 32'h0000_6000;
        tick();
        sena = 1'b0;
        chk("rbusy.stb_before", 32'(dwb_stb), 32'd1);
        srst = 1'b1;
        tick();
        srst = 1'b0;
        chk("rbusy.stb", 32'(dwb_stb), 32'd0);
        chk("rbusy.adr", dwb_adr, 32'd0);
        chk("rbusy.sel", 32'(dwb_sel), 32'd0);
        chk("rbusy.mopc", 32'(mopc), 32'(OPC_NOP));
        dwb_ack = 1'b1; dwb_dti = 32'h7777_7777;
        #1;
        chk("rbusy.mstl", 32'(mstl), 32'd0);
        tick();
        dwb_ack = 1'b0;
        chk("rbusy.mlod", mlod, 32'd0);
        chk("rbusy.stb_after", 32'(dwb_stb), 32'd0);
        exp_mlod = 32'd0; exp_mopc = OPC_NOP;

`ifdef T5_DMEM_TIMEOUT_EN
        // Watchdog expiry with no ack
        sena = 1'b1; xopc = OPC_LOAD; xfn3 = 3'd2; xadr = 32'h0000_7000;
        tick();
        sena = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            chk("tmo.stb", 32'(dwb_stb), 32'd1);
            chk("tmo.mstl", 32'(mstl), 32'd1);
            tick();
        end
        chk("tmo.stb4", 32'(dwb_stb), 32'd1);
        chk("tmo.mstl4", 32'(mstl), 32'd0);
        tick();
        chk("tmo.drop", 32'(dwb_stb), 32'd0);
        chk("tmo.mberr", 32'(mberr), 32'd1);
        chk("tmo.mlod", mlod, 32'hFFFF_FFFF);
        tick();
        chk("tmo.mberr_clr", 32'(mberr), 32'd0);
        // Ack in the expiry cycle wins
        sena = 1'b1; xopc = OPC_LOAD; xfn3 = 3'd2; xadr = 32'h0000_7004;
        tick();
        sena = 1'b0;
        tick(); tick(); tick();
        dwb_ack = 1'b1; dwb_dti = 32'h0BAD_CAFE;
        tick();
        dwb_ack = 1'b0;
        chk("tmo_ack.stb", 32'(dwb_stb), 32'd0);
        chk("tmo_ack.mberr", 32'(mberr), 32'd0);
        chk("tmo_ack.mlod", mlod, 32'h0BAD_CAFE);
        exp_mlod = 32'h0BAD_CAFE;
`else
        // Without the watchdog a transaction waits indefinitely
        sena = 1'b1; xopc = OPC_LOAD; xfn3 = 3'd2; xadr = 32'h0000_7000;
        tick();
        sena = 1'b0;
        for (int c = 0; c < 12; c++) tick();
        chk("wait.stb", 32'(dwb_stb), 32'd1);
        chk("wait.mstl", 32'(mstl), 32'd1);
        chk("wait.mberr", 32'(mberr), 32'd0);
        dwb_ack = 1'b1; dwb_dti = 32'h0BAD_CAFE;
        tick();
        dwb_ack = 1'b0;
        chk("wait.mlod", mlod, 32'h0BAD_CAFE);
        exp_mlod = 32'h0BAD_CAFE;
`endif
        exp_mopc = OPC_LOAD;

        // Randomized transactions
        for (int i = 0; i < 60; i++) begin
            logic [4:0]  opc;
            int          r;
            r = int'($urandom_range(0, 4));
            opc = (r < 2) ? OPC_LOAD : (r < 4) ? OPC_STORE : OPC_OP;
            issue(opc, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                  int'($urandom_range(0, 3)), "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
